// File: rtl/piano_audio_pkg.sv
// Shared constants and types for the piano audio output path.
package piano_audio_pkg;

  localparam int MIDPOINT           = 128;
  localparam int PWM_TOP            = 254;
  localparam int SAMPLE_DIV_DEFAULT = 2268;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SAT
  } mix_state_e;

endpackage

// File: rtl/pwm_dac8.sv
// 8-bit PWM DAC: 255-cycle period, duty double-buffered at the period wrap.
module pwm_dac8
  import piano_audio_pkg::*;
(
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic [7:0] level,
  output logic       pwm_out
);

  logic [7:0] pwm_cnt;
  logic [7:0] duty;

  // Duty only changes between periods, so a period never mixes two levels.
  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty    <= 8'(MIDPOINT);
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (pwm_cnt < duty);
      if (pwm_cnt == 8'(PWM_TOP)) begin
        pwm_cnt <= '0;
        duty    <= level;
      end else begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/voice_mixer_pwm.sv
// Sample-rate strobe, time-multiplexed voice mixer with attenuation and
// saturation, and PWM output stage for the mono amplifier.
module voice_mixer_pwm
  import piano_audio_pkg::*;
#(
  parameter int VOICES     = 8,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
  parameter int SHIFT      = 2
) (
  input  logic                clk_100mhz,
  input  logic                rst_n,
  input  logic [8*VOICES-1:0] voice_q,
  input  logic                mute,
  output logic                sample_switch,
  output logic [7:0]          mix_level,
  output logic                pwm_out,
  output logic                sd_n
);

  localparam int ACC_W = 9 + $clog2(VOICES);
  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int HALF  = SAMPLE_DIV / 2;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  // Attenuate, clamp to signed 8 bits, then re-bias to the unsigned midpoint.
  function automatic logic [7:0] sat_level(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s > SAT_HI) return 8'hFF;
    if (s < SAT_LO) return 8'h00;
    return {~s[7], s[6:0]};
  endfunction

  logic [DIV_W-1:0]        div_cnt;
  logic                    trigger;
  mix_state_e              state, state_nxt;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic [7:0]              voice_arr [VOICES];
  logic signed [8:0]       voice_delta;

  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    assign voice_arr[g] = voice_q[8*g +: 8];
  end

  assign trigger     = (div_cnt == DIV_W'(HALF));
  assign voice_delta = $signed({1'b0, voice_arr[idx]}) - 9'sd128;

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      div_cnt       <= '0;
      sample_switch <= 1'b0;
      sd_n          <= 1'b0;
    end else begin
      div_cnt       <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + 1'b1;
      sample_switch <= (div_cnt < DIV_W'(HALF));
      sd_n          <= ~mute;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = ACC;
      ACC:     if (idx == IDX_W'(VOICES - 1)) state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Voices are read live at their own idx cycle; no snapshot of voice_q.
  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      acc       <= '0;
      idx       <= '0;
      mix_level <= 8'(MIDPOINT);
    end else begin
      case (state)
        IDLE: if (trigger) begin
          acc <= '0;
          idx <= '0;
        end
        ACC: begin
          acc <= acc + ACC_W'(voice_delta);
          idx <= (idx == IDX_W'(VOICES - 1)) ? '0 : idx + 1'b1;
        end
        SAT: mix_level <= mute ? 8'(MIDPOINT) : sat_level(acc);
        default: ;
      endcase
    end
  end

  pwm_dac8 u_pwm (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .level      (mix_level),
    .pwm_out    (pwm_out)
  );

endmodule

// File: tb/tb_voice_mixer_pwm.sv
// Scoreboard bench for voice_mixer_pwm: mix results, divider timing, PWM duty windows, mute.
module tb_voice_mixer_pwm;

  localparam int V    = 8;
  localparam int DIV  = 2268;
  localparam int PWMP = 255;

  logic           clk_100mhz = 1'b0;
  logic           rst_n      = 1'b0;
  logic [8*V-1:0] voice_q;
  logic           mute       = 1'b0;
  logic           sample_switch;
  logic [7:0]     mix_level;
  logic           pwm_out;
  logic           sd_n;

  int checks = 0;
  int errors = 0;
  int pk     = 0;
  int exp_q[$];
  int win_hi[$];
  int mix_pk = 0;

  voice_mixer_pwm #(.VOICES(V), .SAMPLE_DIV(DIV), .SHIFT(2)) dut (
    .clk_100mhz    (clk_100mhz),
    .rst_n         (rst_n),
    .voice_q       (voice_q),
    .mute          (mute),
    .sample_switch (sample_switch),
    .mix_level     (mix_level),
    .pwm_out       (pwm_out),
    .sd_n          (sd_n)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Edge index since reset release: after edge E_j, pk = j + 1.
  always @(posedge clk_100mhz) pk <= rst_n ? pk + 1 : 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  function automatic logic [8*V-1:0] voices(input logic [7:0] v0, v1, v2, rest);
    logic [8*V-1:0] r;
    for (int i = 0; i < V; i++) r[8*i +: 8] = rest;
    r[7:0]   = v0;
    r[15:8]  = v1;
    r[23:16] = v2;
    return r;
  endfunction

  task automatic wait_ss(input logic lvl, input string nm, output int t);
    logic prev;
    prev = sample_switch;
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_100mhz); #1;
      if (sample_switch === lvl && prev !== lvl) begin
        t = pk;
        return;
      end
      prev = sample_switch;
    end
    timeout_fail(nm);
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk_100mhz); #1;
    end
    timeout_fail(nm);
  endtask

  task automatic wait_win(input int n, input string nm);
    for (int i = 0; i < 3000; i++) begin
      if (win_hi.size() > n) return;
      @(posedge clk_100mhz); #1;
    end
    timeout_fail(nm);
  endtask

  task automatic step(input logic [8*V-1:0] v, input int expv);
    voice_q = v;
    exp_q.push_back(expv);
  endtask

  function automatic int win_at(input int n);
    return (win_hi.size() > n) ? win_hi[n] : -1;
  endfunction

  // Scoreboard monitor: mix_level must hold for V edges after the falling
  // edge of sample_switch and take the queued value on edge V+1.
  initial begin : mon_mix
    logic prev_ss;
    int   cnt;
    int   last_exp;
    int   e;
    prev_ss  = 1'b0;
    cnt      = -1;
    last_exp = 128;
    forever begin
      @(posedge clk_100mhz); #1;
      if (!rst_n) begin
        prev_ss = 1'b0;
        cnt     = -1;
      end else begin
        if (prev_ss === 1'b1 && sample_switch === 1'b0) cnt = 0;
        else if (cnt >= 0) cnt++;
        prev_ss = sample_switch;
        if (cnt == V && exp_q.size() > 0)
          chk("mix_hold", int'(mix_level), last_exp);
        if (cnt == V + 1) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mix_level", int'(mix_level), e);
            last_exp = e;
            mix_pk   = pk;
          end
          cnt = -1;
        end
      end
    end
  end

  // PWM high counts per 255-edge window aligned to the post-reset pwm period.
  initial begin : mon_pwm
    int hi;
    hi = 0;
    forever begin
      @(posedge clk_100mhz); #1;
      if (rst_n && pk > 0) begin
        hi += (pwm_out === 1'b1) ? 1 : 0;
        if (pk % PWMP == 0) begin
          win_hi.push_back(hi);
          hi = 0;
        end
      end
    end
  end

  initial begin : stim
    int t_rise, t_fall, t_prev, m;
    voice_q = voices(8'd128, 8'd128, 8'd128, 8'd128);

    repeat (5) @(posedge clk_100mhz);
    #1;
    chk("rst_mix_level", int'(mix_level), 128);
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_sd_n", int'(sd_n), 0);
    chk("rst_sample_switch", int'(sample_switch), 0);

    // Period 0: silence
    exp_q.push_back(128);
    rst_n = 1'b1;
    @(posedge clk_100mhz); #1;
    chk("ss_after_release", int'(sample_switch), 1);
    chk("sd_n_after_release", int'(sd_n), 1);
    t_rise = pk;
    wait_ss(1'b0, "ss_fall", t_fall);
    chk("ss_high_time", t_fall - t_rise, DIV / 2);
    t_prev = t_rise;
    wait_ss(1'b1, "ss_rise", t_rise);
    chk("ss_period", t_rise - t_prev, DIV);

    // Period 1: silence again; PWM duty 128
    step(voices(8'd128, 8'd128, 8'd128, 8'd128), 128);
    wait_win(8, "pwm_win_silence");
    chk("pwm_silence_w0", win_at(0), 128);
    chk("pwm_silence_w8", win_at(8), 128);

    // Period 2: voice0 = 228 -> 100 >> 2 = 25 -> 153
    wait_ss(1'b1, "ss_rise2", t_rise);
    step(voices(8'd228, 8'd128, 8'd128, 8'd128), 153);
    wait_empty("mix_153");
    m = (mix_pk - 1) / PWMP;
    wait_win(m + 1, "pwm_win_153");
    chk("pwm_153", win_at(m + 1), 153);

    // Period 3: 127+127+34 = 288 -> 72 -> 200; duty switches only at the wrap
    wait_ss(1'b1, "ss_rise3", t_rise);
    step(voices(8'd255, 8'd255, 8'd162, 8'd128), 200);
    wait_empty("mix_200");
    m = (mix_pk - 1) / PWMP;
    wait_win(m + 1, "pwm_win_200");
    chk("pwm_glitch_old", win_at(m), 153);
    chk("pwm_glitch_new", win_at(m + 1), 200);

    // Period 4: all 255 -> 1016 >> 2 = 254 -> clamp 127 -> 255
    wait_ss(1'b1, "ss_rise4", t_rise);
    step(voices(8'd255, 8'd255, 8'd255, 8'd255), 255);
    wait_empty("mix_255");
    m = (mix_pk - 1) / PWMP;
    wait_win(m + 1, "pwm_win_255");
    chk("pwm_const_high", win_at(m + 1), 255);

    // Period 5: all 0 -> -1024 >> 2 = -256 -> clamp -128 -> 0
    wait_ss(1'b1, "ss_rise5", t_rise);
    step(voices(8'd0, 8'd0, 8'd0, 8'd0), 0);
    wait_empty("mix_0");
    m = (mix_pk - 1) / PWMP;
    wait_win(m + 1, "pwm_win_0");
    chk("pwm_const_low", win_at(m + 1), 0);

    // Period 6: mute raised during ACC
    wait_ss(1'b1, "ss_rise6", t_rise);
    t_prev = t_rise;
    step(voices(8'd228, 8'd128, 8'd128, 8'd128), 128);
    wait_ss(1'b0, "ss_fall6", t_fall);
    repeat (3) @(posedge clk_100mhz);
    #1;
    mute = 1'b1;
    @(posedge clk_100mhz); #1;
    chk("sd_n_mute", int'(sd_n), 0);
    wait_ss(1'b1, "ss_rise7", t_rise);
    chk("ss_period_mute", t_rise - t_prev, DIV);

    // Period 7: unmuted again, voice0 = 228 -> 153
    mute = 1'b0;
    step(voices(8'd228, 8'd128, 8'd128, 8'd128), 153);
    @(posedge clk_100mhz); #1;
    chk("sd_n_unmute", int'(sd_n), 1);
    wait_empty("mix_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
